// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared definitions for the switch input-conditioning path.
//   IO_DATA_W   : width of the CPU-facing input port words
//   deb_state_t : per-channel debouncer state
// ---------------------------------------------------------------------------
package io_pkg;

  localparam int IO_DATA_W = 32;

  typedef enum logic {
    DEB_STABLE  = 1'b0,
    DEB_PENDING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/io_debounce_chan.sv
// ---------------------------------------------------------------------------
// io_debounce_chan
// One switch channel: a 2-flop synchroniser followed by a stability counter.
// A new synchronised value is committed to 'stable' only after it has been
// seen on DEBOUNCE_CYCLES consecutive edges.
//
// Ports
//   io_clk    : clock, rising edge
//   reset     : asynchronous, active-high
//   sw        : raw asynchronous switch bits
//   stable_q  : debounced value
//   changed   : one-cycle pulse on the edge stable_q takes a new value
//   state_dbg : current FSM state, for observation only
// ---------------------------------------------------------------------------
module io_debounce_chan
  import io_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             io_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] stable_q,
  output logic             changed,
  output deb_state_t       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  deb_state_t       state;

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      stable  <= '0;
      cand    <= '0;
      cnt     <= '0;
      changed <= 1'b0;
      state   <= DEB_STABLE;
    end else begin
      s1      <= sw;
      s2      <= s1;
      changed <= 1'b0;
      case (state)
        DEB_STABLE: begin
          if (s2 != stable) begin
            cand  <= s2;
            cnt   <= CNT_ONE;
            state <= DEB_PENDING;
          end
        end
        DEB_PENDING: begin
          if (s2 == stable) begin
            // Input fell back to the committed value: a glitch, drop it.
            cnt   <= '0;
            state <= DEB_STABLE;
          end else if (s2 != cand) begin
            // A different value appeared: restart the run with it.
            cand <= s2;
            cnt  <= CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            stable  <= cand;
            changed <= 1'b1;
            cnt     <= '0;
            state   <= DEB_STABLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= DEB_STABLE;
        end
      endcase
    end
  end

  assign stable_q  = stable;
  assign state_dbg = state;

endmodule

// File: rtl/io_switch_debouncer.sv
// ---------------------------------------------------------------------------
// io_switch_debouncer
// Conditions two raw slide-switch ports for the io_input register block.
// Each port is synchronised and debounced independently, then zero-extended
// to a 32-bit word that feeds in_port0 / in_port1 directly.
//
// Ports
//   io_clk    : clock, rising edge
//   reset     : asynchronous, active-high; outputs read zero immediately
//   sw0, sw1  : raw asynchronous switch ports, WIDTH bits each
//   out_port0 : debounced sw0, zero-extended to 32 bits
//   out_port1 : debounced sw1, zero-extended to 32 bits
//   changed0  : one-cycle pulse when out_port0 takes a new value
//   changed1  : one-cycle pulse when out_port1 takes a new value
// ---------------------------------------------------------------------------
module io_switch_debouncer
  import io_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 io_clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sw0,
  input  logic [WIDTH-1:0]     sw1,
  output logic [IO_DATA_W-1:0] out_port0,
  output logic [IO_DATA_W-1:0] out_port1,
  output logic                 changed0,
  output logic                 changed1
);

  logic [WIDTH-1:0] stable0;
  logic [WIDTH-1:0] stable1;
  deb_state_t       chan0_state_unused;
  deb_state_t       chan1_state_unused;

  io_debounce_chan #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan0 (
    .io_clk    (io_clk),
    .reset     (reset),
    .sw        (sw0),
    .stable_q  (stable0),
    .changed   (changed0),
    .state_dbg (chan0_state_unused)
  );

  io_debounce_chan #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan1 (
    .io_clk    (io_clk),
    .reset     (reset),
    .sw        (sw1),
    .stable_q  (stable1),
    .changed   (changed1),
    .state_dbg (chan1_state_unused)
  );

  // Unsigned size cast zero-extends and stays legal when WIDTH == 32.
  assign out_port0 = IO_DATA_W'(stable0);
  assign out_port1 = IO_DATA_W'(stable1);

endmodule
